piso_serializer: RTL and testbench

//   Parallel-in/serial-out converter. Accepts one WIDTH-bit word per valid/ready

---
 rtl/piso_serializer.sv | 136 +++++++++++++
 tb/tb_piso_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out converter. Takes one WIDTH-bit word per
//   s_valid/s_ready handshake and sends it out as BEATS = WIDTH/SER_WIDTH
//   beats of SER_WIDTH bits. Each beat carries first/last framing. When the
//   last beat is accepted, a new word can load in the same cycle, so
//   consecutive words leave with no bubble.
//
// Ports
//   clk      in   1          clock, all state updates on the rising edge
//   srst     in   1          synchronous reset, active-high
//   s_valid  in   1          input word valid
//   s_ready  out  1          a word can be accepted this cycle
//   s_data   in   WIDTH      input word
//   m_valid  out  1          serial beat valid
//   m_ready  in   1          downstream accepts the beat
//   m_data   out  SER_WIDTH  serial beat (0 when m_valid is low)
//   m_first  out  1          beat 0 of its word
//   m_last   out  1          beat BEATS-1 of its word
//   busy     out  1          a word is held
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 16,
  parameter int SER_WIDTH = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [SER_WIDTH-1:0] m_data,
  output logic                 m_first,
  output logic                 m_last,
  output logic                 busy
);

  localparam int BEATS = WIDTH / SER_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if ((WIDTH % SER_WIDTH) != 0) begin : g_bad_ser_width
    $error("piso_serializer: SER_WIDTH (%0d) must divide WIDTH (%0d)", SER_WIDTH, WIDTH);
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [WIDTH-1:0]   shift_adv;
  logic               at_last;
  logic               beat_accept;
  logic               load;

  // m_valid is a direct decode of the state. The shift register is zero
  // whenever no word is held, so m_data is also zero then.
  assign m_valid     = (state_reg == ST_SHIFT);
  assign busy        = m_valid;
  assign at_last     = (count_reg == LAST_CNT);
  assign m_first     = m_valid && (count_reg == '0);
  assign m_last      = m_valid && at_last;
  assign beat_accept = m_valid && m_ready;

  // A word can load while idle, or in the same cycle that the final beat of
  // the current word is taken. This gives gap-free back-to-back words.
  assign s_ready = !srst && ((state_reg == ST_IDLE) || (beat_accept && at_last));
  assign load    = s_valid && s_ready;

  // The output beat is always at the "output end" of the register. Each
  // accepted beat moves the register one beat toward that end.
  for (genvar gi = 0; gi < SER_WIDTH; gi++) begin : g_beat_tap
    if (MSB_FIRST) begin : g_msb
      assign m_data[gi] = shift_reg[WIDTH-SER_WIDTH+gi];
    end else begin : g_lsb
      assign m_data[gi] = shift_reg[gi];
    end
  end

  if (MSB_FIRST) begin : g_adv_msb
    assign shift_adv = shift_reg << SER_WIDTH;
  end else begin : g_adv_lsb
    assign shift_adv = shift_reg >> SER_WIDTH;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    shift_next = shift_reg;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          state_next = ST_SHIFT;
          count_next = '0;
          shift_next = s_data;
        end
      end
      ST_SHIFT: begin
        if (beat_accept) begin
          if (at_last) begin
            if (load) begin
              // The last beat leaves and the next word arrives in the same cycle.
              count_next = '0;
              shift_next = s_data;
            end else begin
              state_next = ST_IDLE;
              count_next = '0;
              shift_next = '0;
            end
          end else begin
            count_next = count_reg + CNT_W'(1);
            shift_next = shift_adv;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Three serializer instances run side by side:
//     0: WIDTH=16, SER_WIDTH=4, MSB first
//     1: WIDTH=16, SER_WIDTH=4, LSB first
//     2: WIDTH=8,  SER_WIDTH=8 (one beat per word)
//   A word-level model checks every output of every instance on each falling
//   edge. The model tracks the held word and its beat index, and computes each
//   beat by arithmetic. Directed sequences add literal expectations. A random
//   soak then runs until instance 2 has moved 10k words.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [2:0]  s_valid_v = 3'b000;
  logic [2:0]  m_ready_v = 3'b111;
  logic [15:0] s_data_a [3];
  logic [2:0]  s_ready_v, m_valid_v, m_first_v, m_last_v, busy_v;
  logic [3:0]  md0, md1;
  logic [7:0]  md2;
  logic [15:0] m_data_a [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_data_a[0] = {12'b0, md0};
  assign m_data_a[1] = {12'b0, md1};
  assign m_data_a[2] = {8'b0, md2};

  piso_serializer #(.WIDTH(16), .SER_WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .srst(srst), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]),
    .s_data(s_data_a[0]), .m_valid(m_valid_v[0]), .m_ready(m_ready_v[0]),
    .m_data(md0), .m_first(m_first_v[0]), .m_last(m_last_v[0]), .busy(busy_v[0]));

  piso_serializer #(.WIDTH(16), .SER_WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .srst(srst), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]),
    .s_data(s_data_a[1]), .m_valid(m_valid_v[1]), .m_ready(m_ready_v[1]),
    .m_data(md1), .m_first(m_first_v[1]), .m_last(m_last_v[1]), .busy(busy_v[1]));

  piso_serializer #(.WIDTH(8), .SER_WIDTH(8), .MSB_FIRST(1'b1)) u_reg (
    .clk(clk), .srst(srst), .s_valid(s_valid_v[2]), .s_ready(s_ready_v[2]),
    .s_data(s_data_a[2][7:0]), .m_valid(m_valid_v[2]), .m_ready(m_ready_v[2]),
    .m_data(md2), .m_first(m_first_v[2]), .m_last(m_last_v[2]), .busy(busy_v[2]));

  // Instance geometry, used by the model
  int pw [3] = '{16, 16, 8};
  int ps [3] = '{4, 4, 8};
  bit pm [3] = '{1'b1, 1'b0, 1'b1};

  // Word-level model state
  bit          mdl_held [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] mdl_word [3];
  int          mdl_k    [3] = '{0, 0, 0};
  int          loads    [3] = '{0, 0, 0};

  task automatic chk16(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %b expected %b", name, inst, $time, act, exp);
    end
  endtask

  // Beat k of a word: the chunk at beat position k counted from the output end.
  function automatic logic [15:0] beat_of(input logic [15:0] word, input int w, input int s,
                                          input bit msb, input int k);
    int          pos;
    logic [31:0] t;
    logic [31:0] mask;
    pos  = msb ? (w / s - 1 - k) : k;
    t    = {16'b0, word} >> (pos * s);
    mask = (32'd1 << s) - 32'd1;
    t    = t & mask;
    return t[15:0];
  endfunction

  // Compare outputs against the model, then apply the handshakes that the
  // next rising edge will see. Inputs change only just after rising edges.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int          nb;
        bit          e_last;
        bit          e_rdy;
        logic [15:0] e_data;
        nb     = pw[i] / ps[i];
        e_last = mdl_held[i] && (mdl_k[i] == nb - 1);
        e_data = mdl_held[i] ? beat_of(mdl_word[i], pw[i], ps[i], pm[i], mdl_k[i]) : 16'h0;
        e_rdy  = !srst && (!mdl_held[i] || (m_ready_v[i] && e_last));
        chk1 ("cmp_m_valid", i, m_valid_v[i], mdl_held[i]);
        chk16("cmp_m_data",  i, m_data_a[i], e_data);
        chk1 ("cmp_m_first", i, m_first_v[i], mdl_held[i] && (mdl_k[i] == 0));
        chk1 ("cmp_m_last",  i, m_last_v[i], e_last);
        chk1 ("cmp_busy",    i, busy_v[i], mdl_held[i]);
        chk1 ("cmp_s_ready", i, s_ready_v[i], e_rdy);
        if (srst) begin
          mdl_held[i] = 1'b0;
          mdl_k[i]    = 0;
        end else begin
          if (mdl_held[i] && m_ready_v[i]) begin
            if (e_last) mdl_held[i] = 1'b0;
            else        mdl_k[i]    = mdl_k[i] + 1;
          end
          if (s_valid_v[i] && e_rdy) begin
            mdl_held[i] = 1'b1;
            mdl_word[i] = s_data_a[i];
            mdl_k[i]    = 0;
            loads[i]    = loads[i] + 1;
          end
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check beat sequence on one instance with m_ready held high, one beat per cycle
  task automatic expect_beats(input int inst, input logic [15:0] b0, input logic [15:0] b1,
                              input logic [15:0] b2, input logic [15:0] b3);
    logic [15:0] eb [4];
    eb[0] = b0; eb[1] = b1; eb[2] = b2; eb[3] = b3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1 ("dir_valid", inst, m_valid_v[inst], 1'b1);
      chk16("dir_beat",  inst, m_data_a[inst], eb[k]);
      chk1 ("dir_first", inst, m_first_v[inst], k == 0);
      chk1 ("dir_last",  inst, m_last_v[inst], k == 3);
      $display("inst %0d beat %0d data %h", inst, k, m_data_a[inst]);
      tick();
    end
  endtask

  initial begin
    bit          soak_done;
    logic [2:0]  acc;
    int          cyc;
    logic [15:0] lb [8];
    s_data_a[0] = 16'h0; s_data_a[1] = 16'h0; s_data_a[2] = 16'h0;

    // Pin the model's beat ordering with hand-computed values
    chk16("pin_msb_b0", 0, beat_of(16'hA5C3, 16, 4, 1'b1, 0), 16'hA);
    chk16("pin_msb_b3", 0, beat_of(16'hA5C3, 16, 4, 1'b1, 3), 16'h3);
    chk16("pin_lsb_b0", 1, beat_of(16'hA5C3, 16, 4, 1'b0, 0), 16'h3);
    chk16("pin_lsb_b2", 1, beat_of(16'hA5C3, 16, 4, 1'b0, 2), 16'h5);
    chk16("pin_reg_b0", 2, beat_of(16'h0022, 8, 8, 1'b1, 0), 16'h22);

    // Reset held for three cycles
    repeat (3) begin
      tick();
      @(negedge clk);
      chk1 ("rst_s_ready", 0, s_ready_v[0], 1'b0);
      chk1 ("rst_m_valid", 0, m_valid_v[0], 1'b0);
      chk16("rst_m_data",  0, m_data_a[0], 16'h0);
      chk1 ("rst_busy",    0, busy_v[0], 1'b0);
    end
    tick();
    srst = 1'b0;
    @(negedge clk);
    chk1("rel_s_ready", 0, s_ready_v[0], 1'b1);
    $display("reset released, s_ready=%b", s_ready_v[0]);

    // MSB first word
    tick();
    s_valid_v[0] = 1'b1; s_data_a[0] = 16'hA5C3;
    tick();
    s_valid_v[0] = 1'b0;
    expect_beats(0, 16'hA, 16'h5, 16'hC, 16'h3);
    @(negedge clk);
    chk1("msb_idle", 0, m_valid_v[0], 1'b0);

    // LSB first, next word offered early and held until accepted
    tick();
    s_valid_v[1] = 1'b1; s_data_a[1] = 16'hA5C3;
    tick();
    s_data_a[1] = 16'h1234;
    lb = '{16'h3, 16'hC, 16'h5, 16'hA, 16'h4, 16'h3, 16'h2, 16'h1};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1 ("b2b_valid", 1, m_valid_v[1], 1'b1);
      chk16("b2b_beat",  1, m_data_a[1], lb[k]);
      chk1 ("b2b_first", 1, m_first_v[1], (k == 0) || (k == 4));
      chk1 ("b2b_last",  1, m_last_v[1], (k == 3) || (k == 7));
      if (k < 3)  chk1("b2b_s_ready_lo", 1, s_ready_v[1], 1'b0);
      if (k == 3) chk1("b2b_s_ready_hi", 1, s_ready_v[1], 1'b1);
      $display("inst 1 beat %0d data %h", k, m_data_a[1]);
      tick();
      if (k == 3) s_valid_v[1] = 1'b0;
    end
    @(negedge clk);
    chk1("b2b_idle", 1, m_valid_v[1], 1'b0);

    // Backpressure on beat 1 of 16'hBEEF
    tick();
    s_valid_v[0] = 1'b1; s_data_a[0] = 16'hBEEF;
    tick();
    s_valid_v[0] = 1'b0;
    @(negedge clk);
    chk16("bp_beat0", 0, m_data_a[0], 16'hB);
    tick();
    m_ready_v[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk16("bp_hold_data",  0, m_data_a[0], 16'hE);
      chk1 ("bp_hold_valid", 0, m_valid_v[0], 1'b1);
      chk1 ("bp_hold_rdy",   0, s_ready_v[0], 1'b0);
      $display("inst 0 stalled, data %h", m_data_a[0]);
      tick();
    end
    m_ready_v[0] = 1'b1;
    lb[0] = 16'hE; lb[1] = 16'hE; lb[2] = 16'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk16("bp_resume", 0, m_data_a[0], lb[k]);
      chk1 ("bp_last",   0, m_last_v[0], k == 2);
      tick();
    end
    @(negedge clk);
    chk1("bp_idle", 0, m_valid_v[0], 1'b0);

    // Reset in the middle of 16'hDEAD
    tick();
    s_valid_v[0] = 1'b1; s_data_a[0] = 16'hDEAD;
    tick();
    s_valid_v[0] = 1'b0;
    @(negedge clk);
    chk16("mid_b0", 0, m_data_a[0], 16'hD);
    tick();
    @(negedge clk);
    chk16("mid_b1", 0, m_data_a[0], 16'hE);
    tick();
    srst = 1'b1;
    @(negedge clk);
    chk1("mid_srst_rdy", 0, s_ready_v[0], 1'b0);
    tick();
    srst = 1'b0;
    @(negedge clk);
    chk1 ("mid_flushed_valid", 0, m_valid_v[0], 1'b0);
    chk16("mid_flushed_data",  0, m_data_a[0], 16'h0);
    tick();
    s_valid_v[0] = 1'b1; s_data_a[0] = 16'h0001;
    @(negedge clk);
    chk1("mid_reload_rdy", 0, s_ready_v[0], 1'b1);
    tick();
    s_valid_v[0] = 1'b0;
    expect_beats(0, 16'h0, 16'h0, 16'h0, 16'h1);
    repeat (2) begin
      @(negedge clk);
      chk1("mid_no_stale", 0, m_valid_v[0], 1'b0);
      tick();
    end

    // One-beat words
    s_valid_v[2] = 1'b1; s_data_a[2] = 16'h0011;
    tick();
    s_data_a[2] = 16'h0022;
    @(negedge clk);
    chk16("reg_w0", 2, m_data_a[2], 16'h11);
    chk1 ("reg_w0_first", 2, m_first_v[2], 1'b1);
    chk1 ("reg_w0_last",  2, m_last_v[2], 1'b1);
    chk1 ("reg_w0_rdy",   2, s_ready_v[2], 1'b1);
    tick();
    s_valid_v[2] = 1'b0;
    @(negedge clk);
    chk16("reg_w1", 2, m_data_a[2], 16'h22);
    chk1 ("reg_w1_first", 2, m_first_v[2], 1'b1);
    chk1 ("reg_w1_last",  2, m_last_v[2], 1'b1);
    tick();
    @(negedge clk);
    chk1("reg_idle", 2, m_valid_v[2], 1'b0);
    tick();

    // Random soak. Upstream keeps each word until it is accepted. A rare
    // reset pulse exercises mid-word discard.
    soak_done = 1'b0;
    cyc = 0;
    while (!soak_done && cyc < 60000) begin
      @(negedge clk);
      acc = s_valid_v & s_ready_v;
      tick();
      cyc++;
      srst = ($urandom_range(0, 1999) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!s_valid_v[i] || acc[i]) begin
          s_valid_v[i] = ($urandom_range(0, 3) != 0);
          s_data_a[i]  = (i == 2) ? (16'($urandom) & 16'h00FF) : 16'($urandom);
        end
        m_ready_v[i] = ($urandom_range(0, 3) != 0);
      end
      if (loads[2] >= 10000) soak_done = 1'b1;
    end
    chk1("soak_words_done", 2, soak_done, 1'b1);
    $display("soak: %0d cycles, words %0d/%0d/%0d", cyc, loads[0], loads[1], loads[2]);

    srst = 1'b0;
    s_valid_v = 3'b000;
    m_ready_v = 3'b111;
    repeat (8) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
